dmem_access_ctrl: RTL and testbench
===================================

Name: dmem_access_ctrl

Overview:
Multi-cycle controller between the MEM stage and the word-wide synchronous data RAM.
Sequences LW/LH/LHU/LB/LBU as read-then-extract and SW as a single write.
Sequences SH/SB as read-modify-write, because the RAM has no byte enables.
Holds the pipeline via `stall` until the access completes, and flags misaligned or out-of-range accesses.

Parameters:
BASE, 32'h10010000, byte address of RAM word 0
ADDR_W, 11, RAM word-index width
DEPTH, 2048, RAM words; offsets >= 4*DEPTH are out of range

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req  in  1  access request, held by requester until done
we  in  1  1=store, 0=load
size  in  2  00 word, 01 half, 10 byte, 11 reserved
sign  in  1  loads only: 1 sign-extend, 0 zero-extend
addr  in  32  byte address
wdata  in  32  store data; half in [15:0], byte in [7:0]
stall  out  1  pipeline hold
done  out  1  one-cycle completion pulse
err  out  1  valid with done; access rejected
rdata  out  32  load result, registered, valid from done onward
mem_addr  out  ADDR_W  RAM word index
mem_ren  out  1  RAM read strobe; data appears on mem_rdata next cycle
mem_wen  out  1  RAM write strobe, committed on clk edge
mem_wdata  out  32  RAM write data
mem_rdata  in  32  RAM read data

Behaviour:
- Reset is asynchronous. It forces state IDLE and clears rdata, done, err, mem_ren, mem_wen and the latched request registers to 0.
- Address arithmetic:
  - off = addr - BASE, 32-bit wrap.
  - Word index = off[ADDR_W+1:2]. Lane = off[1:0].
  - Lane 0 is bits [7:0]; lane 3 is bits [31:24]. Half at lane 2 is bits [31:16].
- Error conditions, evaluated in IDLE on req:
  - size=11.
  - size=00 with lane != 0.
  - size=01 with lane[0]=1.
  - off >= 4*DEPTH.
- In IDLE with req=1, addr/we/size/sign/wdata are latched and the FSM leaves IDLE. Inputs are not re-sampled until the next IDLE.
- States, all outputs Moore-decoded from registered state and latched registers:
  - IDLE: req & error -> ERR. req & !we -> READ. req & we & size=00 -> WRITE. req & we & sub-word -> READ.
  - READ: mem_ren=1, mem_addr=index -> CAPT.
  - CAPT: if load, rdata <= extract(mem_rdata); if store, merge <= mem_rdata with the selected lane(s) replaced by wdata[7:0] or wdata[15:0]. Load -> DONE; store -> WRITE.
  - WRITE: mem_wen=1, mem_wdata = merge (sub-word) or latched wdata (word) -> DONE.
  - DONE: done=1, err=0 -> IDLE.
  - ERR: done=1, err=1, no RAM strobe -> IDLE.
- Extraction:
  - Word: as is.
  - Half: lane[1] selects the upper or lower half.
  - Byte: lane selects one of four bytes.
  - Then sign- or zero-extend per the latched sign.
- Cycle counts, with T0 = accept cycle:
  - Load: done at T3.
  - SW: wen at T1, done at T2.
  - SH/SB: ren T1, wen T3, done T4.
  - Error: done+err at T1.
- stall = (state != IDLE && state != DONE && state != ERR) | (state == IDLE & req). It is combinational, so the pipeline is held during the accept cycle, and it drops in the done cycle.
- req in DONE/ERR is ignored. A new request is accepted in IDLE the following cycle, one idle bubble minimum.
- mem_ren and mem_wen are never high together. mem_wen is never high in any error sequence.
- rdata holds its value until the next completed load. Stores, errors and reset-free idle cycles do not change it.
- Reset mid-operation aborts immediately. No write is issued after reset deasserts, including when reset is asserted in CAPT or WRITE. A write in progress on the same edge is not guaranteed.

Test Plan:
1. Signed LB: RAM[0]=0x1234F678, req LB addr 0x10010001 sign=1 -> rdata 0xFFFFFFF6 and done at T3. Repeat with sign=0 -> 0x000000F6.
2. Signed LH: RAM[1]=0x80017FFF, addr 0x10010006 -> rdata 0xFFFF8001. LHU at addr 0x10010004 -> 0x00007FFF.
3. SB: RAM[2]=0x11223344, addr 0x1001000B wdata 0xFFFFFFAB -> ren T1, wen T3 with mem_wdata 0xAB223344, done T4, stall high T0..T3. SH at addr 0x10010008 with wdata 0x5566 -> 0xAB225566.
4. SW addr 0x1001000C wdata 0xDEADBEEF -> wen T1 at index 3, done T2, no ren. Then LW at the same address returns 0xDEADBEEF.
5. Errors -> each gives done=err=1 at T1 with no ren/wen, and rdata unchanged:
   - SH at 0x10010001.
   - LW at 0x10010002.
   - size=11.
   - addr 0x10010000+4*DEPTH.
   - addr 0x1000FFFC (below BASE, wraps).
6. Assert rst during CAPT of an SB -> state IDLE, outputs 0, no wen in any later cycle. Back-to-back req held high -> second access is accepted the cycle after done.

Source files
------------

// File: rtl/dmem_access_ctrl.sv
// MEM-stage controller for a word-wide synchronous RAM without byte enables:
// loads are read-then-extract, SW is a single write, SH/SB are read-modify-write.
module dmem_access_ctrl #(
    parameter logic [31:0] BASE   = 32'h1001_0000,
    parameter int          ADDR_W = 11,
    parameter int          DEPTH  = 2048
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sign,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_ren,
    output logic              mem_wen,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [31:0] RANGE = 32'(4 * DEPTH);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CAPT, S_WRITE, S_DONE, S_ERR
    } state_t;

    state_t            state_q;
    logic [ADDR_W-1:0] idx_q;
    logic [1:0]        lane_q;
    logic [1:0]        size_q;
    logic              we_q;
    logic              sign_q;
    logic [31:0]       wdata_q;
    logic [31:0]       rdata_q;
    logic [31:0]       mem_wdata_q;
    logic              done_q;
    logic              err_q;
    logic              ren_q;
    logic              wen_q;

    logic [31:0] off_d;
    logic        req_err_d;
    logic [31:0] load_d;
    logic [31:0] merge_d;
    logic [7:0]  byte_d;
    logic [15:0] half_d;

    // Offset wraps, so addresses below BASE land far out of range.
    always_comb begin
        off_d     = addr - BASE;
        req_err_d = (size == 2'b11)
                  || (size == 2'b00 && off_d[1:0] != 2'b00)
                  || (size == 2'b01 && off_d[0])
                  || (off_d >= RANGE);
    end

    always_comb begin
        byte_d  = mem_rdata[{lane_q, 3'b000} +: 8];
        half_d  = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        load_d  = mem_rdata;
        merge_d = mem_rdata;
        case (size_q)
            2'b00:   load_d = mem_rdata;
            2'b01:   load_d = {{16{sign_q & half_d[15]}}, half_d};
            default: load_d = {{24{sign_q & byte_d[7]}}, byte_d};
        endcase
        if (size_q == 2'b01) begin
            if (lane_q[1]) merge_d[31:16] = wdata_q[15:0];
            else           merge_d[15:0]  = wdata_q[15:0];
        end else begin
            merge_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end
    end

    // Strobes are registered alongside the state they belong to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            lane_q      <= '0;
            size_q      <= '0;
            we_q        <= 1'b0;
            sign_q      <= 1'b0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            mem_wdata_q <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            ren_q  <= 1'b0;
            wen_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        idx_q   <= off_d[ADDR_W+1:2];
                        lane_q  <= off_d[1:0];
                        size_q  <= size;
                        we_q    <= we;
                        sign_q  <= sign;
                        wdata_q <= wdata;
                        if (req_err_d) begin
                            state_q <= S_ERR;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (!we || size != 2'b00) begin
                            state_q <= S_READ;
                            ren_q   <= 1'b1;
                        end else begin
                            state_q     <= S_WRITE;
                            wen_q       <= 1'b1;
                            mem_wdata_q <= wdata;
                        end
                    end
                end
                S_READ: state_q <= S_CAPT;
                S_CAPT: begin
                    if (we_q) begin
                        mem_wdata_q <= merge_d;
                        state_q     <= S_WRITE;
                        wen_q       <= 1'b1;
                    end else begin
                        rdata_q <= load_d;
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                S_WRITE: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign stall     = (state_q != S_IDLE && state_q != S_DONE && state_q != S_ERR)
                     || (state_q == S_IDLE && req);
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_addr  = idx_q;
    assign mem_ren   = ren_q;
    assign mem_wen   = wen_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl with a behavioural synchronous RAM.
module tb_dmem_access_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [10:0] mem_addr;
    logic        mem_ren;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    always #5 clk = ~clk;

    dmem_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .we        (we),
        .size      (size),
        .sign      (sign),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .mem_addr  (mem_addr),
        .mem_ren   (mem_ren),
        .mem_wen   (mem_wen),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    logic [31:0] ram [0:2047];
    int wen_count   = 0;
    int clash_count = 0;

    always @(posedge clk) begin
        if (mem_ren) mem_rdata <= ram[mem_addr];
        if (mem_wen) ram[mem_addr] <= mem_wdata;
        if (mem_wen) wen_count <= wen_count + 1;
        if (mem_ren && mem_wen) clash_count <= clash_count + 1;
    end

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    int          done_t, ren_t, wen_t, ren_n;
    logic        err_s;
    logic [31:0] wen_data;
    logic [10:0] wen_addr;
    logic [15:0] stall_m;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called one time unit after a rising edge with the DUT idle; returns likewise.
    task automatic run(input logic w, input logic [1:0] sz, input logic sg,
                       input logic [31:0] a, input logic [31:0] wd);
        req = 1'b1; we = w; size = sz; sign = sg; addr = a; wdata = wd;
        done_t = -1; ren_t = -1; wen_t = -1; ren_n = 0;
        err_s = 1'b0; wen_data = '0; wen_addr = '0; stall_m = '0;
        for (int t = 0; t < 10; t++) begin
            #1;
            stall_m[t] = stall;
            if (mem_ren) begin
                ren_n++;
                if (ren_t < 0) ren_t = t;
            end
            if (mem_wen) begin
                wen_t    = t;
                wen_data = mem_wdata;
                wen_addr = mem_addr;
            end
            if (done) begin
                done_t = t;
                err_s  = err;
                break;
            end
            @(posedge clk); #1;
        end
        req = 1'b0; we = 1'b0; size = 2'b00; sign = 1'b0;
        @(posedge clk); #1;
    endtask

    logic        e_we   [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [1:0]  e_size [5] = '{2'b01, 2'b00, 2'b11, 2'b00, 2'b00};
    logic [31:0] e_addr [5] = '{32'h1001_0001, 32'h1001_0002, 32'h1001_0000,
                                32'h1001_2000, 32'h1000_FFFC};
    int wc;

    initial begin
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; sign = 1'b0;
        addr = '0; wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_err", {31'b0, err}, 32'd0);
        chk("rst_ren", {31'b0, mem_ren}, 32'd0);
        chk("rst_wen", {31'b0, mem_wen}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_stall", {31'b0, stall}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Preload through SW (word store, no read)
        run(1'b1, 2'b00, 1'b0, 32'h1001_0000, 32'h1234_F678);
        chk("sw0_done_t", 32'(done_t), 32'd2);
        chk("sw0_wen_t", 32'(wen_t), 32'd1);
        chk("sw0_ren_n", 32'(ren_n), 32'd0);
        chk("sw0_wdata", wen_data, 32'h1234_F678);
        run(1'b1, 2'b00, 1'b0, 32'h1001_0004, 32'h8001_7FFF);
        chk("sw1_addr", {21'b0, wen_addr}, 32'd1);
        run(1'b1, 2'b00, 1'b0, 32'h1001_0008, 32'h1122_3344);
        chk("sw2_addr", {21'b0, wen_addr}, 32'd2);

        run(1'b0, 2'b10, 1'b1, 32'h1001_0001, 32'h0);
        $display("LB  addr=10010001 rdata=%h done_t=%0d", rdata, done_t);
        chk("lb_rdata", rdata, 32'hFFFF_FFF6);
        chk("lb_done_t", 32'(done_t), 32'd3);
        chk("lb_ren_t", 32'(ren_t), 32'd1);
        chk("lb_err", {31'b0, err_s}, 32'd0);
        chk("lb_stall", {16'b0, stall_m}, 32'h0000_0007);
        chk("lb_nowen", 32'(wen_t), 32'hFFFF_FFFF);

        run(1'b0, 2'b10, 1'b0, 32'h1001_0001, 32'h0);
        $display("LBU addr=10010001 rdata=%h", rdata);
        chk("lbu_rdata", rdata, 32'h0000_00F6);

        run(1'b0, 2'b01, 1'b1, 32'h1001_0006, 32'h0);
        $display("LH  addr=10010006 rdata=%h", rdata);
        chk("lh_rdata", rdata, 32'hFFFF_8001);

        run(1'b0, 2'b01, 1'b0, 32'h1001_0004, 32'h0);
        $display("LHU addr=10010004 rdata=%h", rdata);
        chk("lhu_rdata", rdata, 32'h0000_7FFF);

        run(1'b1, 2'b10, 1'b0, 32'h1001_000B, 32'hFFFF_FFAB);
        $display("SB  addr=1001000B wen_data=%h wen_t=%0d done_t=%0d", wen_data, wen_t, done_t);
        chk("sb_ren_t", 32'(ren_t), 32'd1);
        chk("sb_ren_n", 32'(ren_n), 32'd1);
        chk("sb_wen_t", 32'(wen_t), 32'd3);
        chk("sb_wdata", wen_data, 32'hAB22_3344);
        chk("sb_waddr", {21'b0, wen_addr}, 32'd2);
        chk("sb_done_t", 32'(done_t), 32'd4);
        chk("sb_stall", {16'b0, stall_m}, 32'h0000_000F);
        chk("sb_rdata_keep", rdata, 32'h0000_7FFF);

        run(1'b1, 2'b01, 1'b0, 32'h1001_0008, 32'h0000_5566);
        $display("SH  addr=10010008 wen_data=%h", wen_data);
        chk("sh_wdata", wen_data, 32'hAB22_5566);

        run(1'b1, 2'b00, 1'b0, 32'h1001_000C, 32'hDEAD_BEEF);
        $display("SW  addr=1001000C wen_addr=%0d done_t=%0d", wen_addr, done_t);
        chk("sw_wen_t", 32'(wen_t), 32'd1);
        chk("sw_waddr", {21'b0, wen_addr}, 32'd3);
        chk("sw_done_t", 32'(done_t), 32'd2);
        chk("sw_ren_n", 32'(ren_n), 32'd0);

        run(1'b0, 2'b00, 1'b0, 32'h1001_000C, 32'h0);
        $display("LW  addr=1001000C rdata=%h", rdata);
        chk("lw_rdata", rdata, 32'hDEAD_BEEF);
        chk("lw_done_t", 32'(done_t), 32'd3);

        for (int i = 0; i < 5; i++) begin
            run(e_we[i], e_size[i], 1'b0, e_addr[i], 32'h0000_00AA);
            $display("ERR case=%0d addr=%h done_t=%0d err=%0d", i, e_addr[i], done_t, err_s);
            chk($sformatf("err%0d_done_t", i), 32'(done_t), 32'd1);
            chk($sformatf("err%0d_err", i), {31'b0, err_s}, 32'd1);
            chk($sformatf("err%0d_ren_n", i), 32'(ren_n), 32'd0);
            chk($sformatf("err%0d_nowen", i), 32'(wen_t), 32'hFFFF_FFFF);
            chk($sformatf("err%0d_rdata", i), rdata, 32'hDEAD_BEEF);
        end

        // Reset asserted while an SB sits in CAPT
        req = 1'b1; we = 1'b1; size = 2'b10; sign = 1'b0;
        addr = 32'h1001_0008; wdata = 32'h0000_0000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        wc = wen_count;
        rst = 1'b1; req = 1'b0;
        #1;
        $display("RST in CAPT stall=%0d done=%0d ren=%0d wen=%0d rdata=%h", stall, done, mem_ren, mem_wen, rdata);
        chk("arst_stall", {31'b0, stall}, 32'd0);
        chk("arst_done", {31'b0, done}, 32'd0);
        chk("arst_ren", {31'b0, mem_ren}, 32'd0);
        chk("arst_wen", {31'b0, mem_wen}, 32'd0);
        chk("arst_rdata", rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; we = 1'b0; size = 2'b00;
        repeat (5) @(posedge clk);
        #1;
        chk("arst_no_wen", 32'(wen_count), 32'(wc));
        run(1'b0, 2'b00, 1'b0, 32'h1001_0008, 32'h0);
        $display("LW  addr=10010008 after abort rdata=%h", rdata);
        chk("arst_ram_kept", rdata, 32'hAB22_5566);

        // Back-to-back: req held through done
        req = 1'b1; we = 1'b0; size = 2'b00; sign = 1'b0; addr = 32'h1001_000C;
        done_t = -1;
        for (int t = 0; t < 10; t++) begin
            #1;
            if (done) begin done_t = t; break; end
            @(posedge clk); #1;
        end
        chk("b2b_first_done_t", 32'(done_t), 32'd3);
        addr = 32'h1001_0000;
        @(posedge clk); #2;
        chk("b2b_accept_stall", {31'b0, stall}, 32'd1);
        chk("b2b_accept_noren", {31'b0, mem_ren}, 32'd0);
        @(posedge clk); #2;
        chk("b2b_ren", {31'b0, mem_ren}, 32'd1);
        done_t = -1;
        for (int t = 0; t < 10; t++) begin
            if (done) begin done_t = t; break; end
            @(posedge clk); #2;
        end
        req = 1'b0;
        $display("B2B second rdata=%h", rdata);
        chk("b2b_second_done", 32'(done_t), 32'd2);
        chk("b2b_second_rdata", rdata, 32'h1234_F678);
        @(posedge clk); #1;
        chk("no_ren_wen_clash", 32'(clash_count), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: timeout at %0t", $time);
        $fatal(1, "timeout");
    end

endmodule
